pipelined_barrel_rotator: RTL and testbench
===========================================

Name: pipelined_barrel_rotator

Overview:
- Runtime-controlled successor to the fixed circular-shift blocks.
- Shift/rotate amount and mode are per-beat inputs, not parameters.
- Datapath is a log2(W)-stage pipelined barrel shifter with a valid/ready handshake on both sides and bubble-collapsing backpressure.
- Sits in the arithmetic datapath wherever variable rotates or shifts are needed at one beat per clock.

Parameters:
- W, 8, data width; power of two, >= 2.
- AW, $clog2(W), shift-amount width and pipeline depth (number of stages); derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- up_valid  in  1  input beat valid.
- up_ready  out  1  block can accept an input beat this cycle.
- up_data  in  W  operand.
- up_amt  in  AW  shift amount, 0..W-1.
- up_mode  in  2  operation: 00 ROL, 01 ROR, 10 SHR (logical right), 11 SAR (arithmetic right).
- down_valid  out  1  output beat valid.
- down_ready  in  1  downstream accepts the beat.
- down_data  out  W  result.
- busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Pipeline structure:
  - AW register stages, numbered 0..AW-1.
  - Stage k holds valid v[k], partial data, remaining amount bits [AW-1:k+1] and mode.
  - Stage k applies a shift of 2^k when amount bit k = 1; otherwise data passes unchanged.
- Per-stage operation for shift s = 2^k:
  - ROL: {d[W-1-s:0], d[W-1:W-s]}.
  - ROR: {d[s-1:0], d[W-1:s]}.
  - SHR: zero fill from the MSB side.
  - SAR: fill with the original operand MSB, carried through the pipeline with the mode.
- Reset (rst_n low, asynchronous):
  - All v[k] clear to 0.
  - down_valid = 0, busy = 0, up_ready = 1.
  - Data registers need no reset; down_data is don't-care while down_valid = 0.
- Handshake:
  - A transfer occurs on a clock edge where valid && ready are both high.
  - ready[AW] = down_ready.
  - Stage k loads when ~v[k] | ready[k+1]. This is combinational and collapses bubbles.
  - up_ready = ~v[0] | ready[1].
  - down_valid = v[AW-1]; down_data = stage AW-1 data.
  - v[k] next = v[k-1] when stage k loads (v[-1] = up_valid); otherwise v[k] holds.
  - A stage that does not load holds its data stable.
  - Once down_valid = 1, down_data must not change until the beat is accepted.
- Latency and throughput:
  - A beat accepted at edge t is presented on down_valid after edge t+AW-1, i.e. AW clocks of latency, when there is no backpressure.
  - Sustained throughput is one beat per clock while down_ready = 1.
  - No combinational path from up_* to down_*.
- Boundary conditions:
  - amt = 0: result equals the operand for every mode.
  - amt = W-1 with SAR: result is all copies of the MSB.
  - Pipeline full with down_ready = 0: up_ready = 0; nothing is lost, dropped or duplicated.
  - Acceptance at output and input in the same cycle while full: both transfers occur and the pipeline stays full.
  - Beats emerge in acceptance order.
  - up_data, up_amt and up_mode are sampled only at a transfer edge.
  - Reset mid-operation: all in-flight beats are discarded and the outputs take reset values immediately (asynchronously).
- busy = OR of v[0..AW-1].

Test Plan (W=8, AW=3):
- ROR 0xA1 by 3, down_ready=1 -> down_data=0x34, down_valid exactly 3 clocks after acceptance, single beat.
- ROL 0xA1 by 3; SHR 0x80 by 7; SAR 0x80 by 7; SAR 0x7F by 7 -> 0x0D, 0x01, 0xFF, 0x00 respectively.
- amt=0 for all 4 modes with 0x5A -> 0x5A each. Back-to-back stream of 16 beats -> 16 outputs on 16 consecutive cycles after initial latency.
- down_ready=0 while 5 beats are offered -> exactly 3 accepted and up_ready=0 after that. Raise down_ready -> all 5 results emerge in order, no gaps beyond one bubble, none duplicated. down_data stays stable during the stall.
- Random modes, amounts and data, with random up_valid/down_ready over 2000 cycles, checked against a reference model via scoreboard -> zero mismatches, counts equal.
- Assert rst_n low for 1 cycle with 3 beats in flight -> down_valid and busy drop immediately, up_ready=1. No stale beat appears after release; the next accepted beat is correct.

Source files
------------

// File: rtl/pipelined_barrel_rotator.sv
// Runtime-controlled rotate/shift unit: one log2(W) barrel stage per pipeline
// register, with valid/ready on both sides and bubble-collapsing backpressure.
module pipelined_barrel_rotator #(
  parameter  int W  = 8,
  localparam int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [W-1:0]  up_data,
  input  logic [AW-1:0] up_amt,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [W-1:0]  down_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    MODE_ROL = 2'b00,
    MODE_ROR = 2'b01,
    MODE_SHR = 2'b10,
    MODE_SAR = 2'b11
  } mode_e;

  // Per-stage state; the amount is pre-shifted so each stage consumes bit 0.
  logic [AW-1:0] v_q, v_d;
  logic [W-1:0]  data_q [AW];
  logic [W-1:0]  data_d [AW];
  logic [AW-1:0] amt_q  [AW];
  logic [AW-1:0] amt_d  [AW];
  mode_e         mode_q [AW];
  mode_e         mode_d [AW];
  logic [AW-1:0] fill_q, fill_d;

  // Inputs feeding each stage: the upstream port for stage 0, else the previous stage.
  logic [AW-1:0] src_v, src_fill;
  logic [W-1:0]  src_data [AW];
  logic [AW-1:0] src_amt  [AW];
  mode_e         src_mode [AW];
  logic [AW:0]   rdy;

  function automatic logic [W-1:0] stage_op(input logic [W-1:0] d, input mode_e mode,
                                            input logic fill, input logic en, input int s);
    logic [W-1:0] fill_mask;
    fill_mask = ~({W{1'b1}} >> s);
    if (!en) return d;
    unique case (mode)
      MODE_ROL: return (d << s) | (d >> (W - s));
      MODE_ROR: return (d >> s) | (d << (W - s));
      MODE_SHR: return d >> s;
      default:  return (d >> s) | (fill ? fill_mask : '0);
    endcase
  endfunction

  always_comb begin
    src_v[0]    = up_valid;
    src_data[0] = up_data;
    src_amt[0]  = up_amt;
    src_mode[0] = mode_e'(up_mode);
    src_fill[0] = up_data[W-1];
    for (int k = 1; k < AW; k++) begin
      src_v[k]    = v_q[k-1];
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_mode[k] = mode_q[k-1];
      src_fill[k] = fill_q[k-1];
    end

    // A stage may load when it is empty or its successor is loading this cycle.
    rdy[AW] = down_ready;
    for (int k = AW - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end

    for (int k = 0; k < AW; k++) begin
      v_d[k]    = rdy[k] ? src_v[k] : v_q[k];
      data_d[k] = stage_op(src_data[k], src_mode[k], src_fill[k], src_amt[k][0], 1 << k);
      amt_d[k]  = src_amt[k] >> 1;
      mode_d[k] = src_mode[k];
      fill_d[k] = src_fill[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  // NOTE: payload registers are deliberately left without reset; they are only
  // observed behind a valid bit, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    for (int k = 0; k < AW; k++) begin
      if (rdy[k] && src_v[k]) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
        mode_q[k] <= mode_d[k];
        fill_q[k] <= fill_d[k];
      end
    end
  end

  assign up_ready   = rdy[0];
  assign down_valid = v_q[AW-1];
  assign down_data  = data_q[AW-1];
  assign busy       = |v_q;

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Scoreboard bench for pipelined_barrel_rotator: drivers push expected results
// on acceptance, a monitor pops and compares on every output transfer.
module tb_pipelined_barrel_rotator;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [W-1:0]  up_data = '0;
  logic [AW-1:0] up_amt = '0;
  logic [1:0]    up_mode = '0;
  logic          down_valid;
  logic          down_ready = 1'b1;
  logic [W-1:0]  down_data;
  logic          busy;

  pipelined_barrel_rotator #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_amt(up_amt), .up_mode(up_mode),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           acc_edge;
    bit           chk_lat;
  } exp_t;

  exp_t         sb_q[$];
  int           pop_edges[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           out_count = 0;
  int           acc_count = 0;
  bit           held_v = 1'b0;
  logic [W-1:0] held_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input int amt, input logic [1:0] mode);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (mode)
        2'b00:   r[i] = d[(i + W - amt) % W];
        2'b01:   r[i] = d[(i + amt) % W];
        2'b10:   r[i] = (i + amt < W) ? d[i + amt] : 1'b0;
        default: r[i] = (i + amt < W) ? d[i + amt] : d[W-1];
      endcase
    end
    return r;
  endfunction

  // Called at a falling edge; returns at a falling edge after the beat is accepted.
  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] amt, input logic [1:0] mode,
                      input logic [W-1:0] exp, input bit lat);
    exp_t e;
    bit   done = 1'b0;
    up_valid = 1'b1;
    up_data  = d;
    up_amt   = amt;
    up_mode  = mode;
    for (int n = 0; n < 200 && !done; n++) begin
      #4;
      if (up_ready) begin
        e.data = exp; e.acc_edge = cyc + 1; e.chk_lat = lat;
        sb_q.push_back(e);
        acc_count++;
        done = 1'b1;
      end
      @(negedge clk);
    end
    up_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no up_ready expected acceptance of 0x%0h", d);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb_q.size() > 0; n++) @(negedge clk);
    check("drain_empty", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    check("drain_idle", busy, 1'b0);
  endtask

  // Monitor: samples one time unit before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (held_v && down_valid) check("stall_stable", down_data, held_d);
        held_v = down_valid && !down_ready;
        held_d = down_data;
        if (down_valid && down_ready) begin
          out_count++;
          pop_edges.push_back(cyc + 1);
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output: got 0x%0h expected none", down_data);
          end else begin
            e = sb_q.pop_front();
            check("data", down_data, e.data);
            if (e.chk_lat) check("latency", cyc + 1 - e.acc_edge, AW);
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, accb, outb;
    bit accepted;

    repeat (2) @(negedge clk);
    check("rst_down_valid", down_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_up_ready", up_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat with latency check.
    send(8'hA1, 3'd3, 2'b01, 8'h34, 1'b1);
    drain();
    check("single_beat", out_count, 1);

    send(8'hA1, 3'd3, 2'b00, 8'h0D, 1'b1);
    send(8'h80, 3'd7, 2'b10, 8'h01, 1'b1);
    send(8'h80, 3'd7, 2'b11, 8'hFF, 1'b1);
    send(8'h7F, 3'd7, 2'b11, 8'h00, 1'b1);
    for (int m = 0; m < 4; m++) send(8'h5A, 3'd0, 2'(m), 8'h5A, 1'b1);
    drain();

    // Back-to-back stream of 16 beats.
    base = pop_edges.size();
    outb = out_count;
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 37 + 5), 3'(i), 2'(i), ref_op(8'(i * 37 + 5), i % 8, 2'(i)), 1'b1);
    end
    drain();
    check("stream_count", out_count - outb, 16);
    check("stream_consecutive", pop_edges[base + 15] - pop_edges[base], 15);

    // Backpressure: 5 beats offered, only 3 fit while the output stalls.
    down_ready = 1'b0;
    accb = acc_count;
    outb = out_count;
    base = pop_edges.size();
    fork
      begin
        send(8'h01, 3'd1, 2'b01, 8'h80, 1'b0);
        send(8'h01, 3'd1, 2'b00, 8'h02, 1'b0);
        send(8'hF0, 3'd4, 2'b10, 8'h0F, 1'b0);
        send(8'h90, 3'd2, 2'b11, 8'hE4, 1'b0);
        send(8'h81, 3'd4, 2'b00, 8'h18, 1'b0);
      end
    join_none
    repeat (10) @(negedge clk);
    check("bp_accepted", acc_count - accb, 3);
    check("bp_up_ready", up_ready, 1'b0);
    check("bp_down_valid", down_valid, 1'b1);
    check("bp_no_output", out_count - outb, 0);
    down_ready = 1'b1;
    for (int n = 0; n < 100 && acc_count - accb < 5; n++) @(negedge clk);
    drain();
    check("bp_out_count", out_count - outb, 5);
    for (int i = 1; i < 5; i++) begin
      check("bp_gap", (pop_edges[base + i] - pop_edges[base + i - 1]) <= 2, 1'b1);
    end

    // Random traffic against the reference model.
    accb = acc_count;
    outb = out_count;
    for (int c = 0; c < 2000; c++) begin
      exp_t e;
      accepted = 1'b0;
      down_ready = ($urandom_range(0, 3) != 0);
      if (!up_valid && $urandom_range(0, 1) == 1) begin
        up_valid = 1'b1;
        up_data  = 8'($urandom);
        up_amt   = 3'($urandom);
        up_mode  = 2'($urandom);
      end
      #4;
      if (up_valid && up_ready) begin
        e.data = ref_op(up_data, int'(up_amt), up_mode);
        e.acc_edge = cyc + 1; e.chk_lat = 1'b0;
        sb_q.push_back(e);
        acc_count++;
        accepted = 1'b1;
      end
      @(negedge clk);
      if (accepted) up_valid = 1'b0;
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    drain();
    check("rand_counts_equal", out_count - outb, acc_count - accb);

    // Reset with three beats in flight.
    down_ready = 1'b0;
    send(8'h11, 3'd1, 2'b00, 8'h22, 1'b0);
    send(8'h22, 3'd1, 2'b00, 8'h44, 1'b0);
    send(8'h44, 3'd1, 2'b00, 8'h88, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_down_valid", down_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_up_ready", up_ready, 1'b1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    down_ready = 1'b1;
    outb = out_count;
    send(8'hA1, 3'd3, 2'b01, 8'h34, 1'b1);
    drain();
    check("post_rst_count", out_count - outb, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
